// File: rtl/music_sequencer.sv
// Single-voice music sequencer: walks a note ROM at a programmable tick rate,
// decodes note/duration words and drives a square-wave tone at the note pitch.
// Play/pause/stop/loop control; the ROM has one cycle of read latency.
module music_sequencer #(
    parameter int unsigned CLK_HZ   = 1_000_000,
    parameter int unsigned TICK_HZ  = 4,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned SONG_LEN = 139,
    parameter int unsigned DUR_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              play,
    input  logic              pause,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DUR_W+3:0]  rom_data,
    output logic              tone,
    output logic [3:0]        note_code,
    output logic              high,
    output logic              busy,
    output logic              done
);

    localparam int unsigned TICK   = CLK_HZ / TICK_HZ;
    localparam int unsigned TICK_W = $clog2(TICK);
    localparam int unsigned TONE_W = $clog2(CLK_HZ / 2 + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

    typedef logic [TONE_W-1:0] hp_t;

    // Half period in clocks for note code n, saturated to 1 for slow clocks.
    function automatic hp_t hp(input int n);
        int unsigned f_hz;
        int unsigned q;
        case (n)
            1:       f_hz = 262;
            2:       f_hz = 294;
            3:       f_hz = 330;
            4:       f_hz = 349;
            5:       f_hz = 392;
            6:       f_hz = 440;
            7:       f_hz = 494;
            8:       f_hz = 523;
            9:       f_hz = 587;
            10:      f_hz = 659;
            11:      f_hz = 698;
            12:      f_hz = 784;
            13:      f_hz = 880;
            14:      f_hz = 988;
            15:      f_hz = 1047;
            default: f_hz = 0;
        endcase
        if (f_hz == 0) begin
            return hp_t'(1);
        end
        q = CLK_HZ / (2 * f_hz);
        if (q < 1) begin
            q = 1;
        end
        return hp_t'(q);
    endfunction

    localparam hp_t HP_TABLE [16] = '{
        hp(0),  hp(1),  hp(2),  hp(3),  hp(4),  hp(5),  hp(6),  hp(7),
        hp(8),  hp(9),  hp(10), hp(11), hp(12), hp(13), hp(14), hp(15)
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_PLAY,
        ST_PAUSED
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] pos, pos_d;
    logic [3:0]        note_d;
    logic [DUR_W-1:0]  dur_cnt, dur_d;
    logic [TICK_W-1:0] tick_cnt, tick_d;
    hp_t               tone_cnt, tone_cnt_d;
    logic              tone_d;
    logic              done_d;

    logic tick_wrap;
    logic tone_wrap;
    hp_t  hp_cur;

    assign hp_cur    = HP_TABLE[note_code];
    assign tick_wrap = (tick_cnt == TICK_LAST);
    assign tone_wrap = (tone_cnt == hp_cur - hp_t'(1));

    assign rom_addr = pos;
    assign high     = note_code[3];
    assign busy     = (state != ST_IDLE);

    // Register all sequencer state; everything clears asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state     <= ST_IDLE;
            pos       <= '0;
            note_code <= '0;
            dur_cnt   <= '0;
            tick_cnt  <= '0;
            tone_cnt  <= '0;
            tone      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            pos       <= pos_d;
            note_code <= note_d;
            dur_cnt   <= dur_d;
            tick_cnt  <= tick_d;
            tone_cnt  <= tone_cnt_d;
            tone      <= tone_d;
            done      <= done_d;
        end
    end

    // Next-state and datapath update; stop beats pause beats play.
    always_comb begin
        // NOTE: every next value gets a hold default first so no path infers a latch.
        state_d    = state;
        pos_d      = pos;
        note_d     = note_code;
        dur_d      = dur_cnt;
        tick_d     = tick_cnt;
        tone_cnt_d = tone_cnt;
        tone_d     = tone;
        done_d     = 1'b0;

        if (stop) begin
            state_d    = ST_IDLE;
            pos_d      = '0;
            note_d     = '0;
            dur_d      = '0;
            tick_d     = '0;
            tone_cnt_d = '0;
            tone_d     = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (play) begin
                        pos_d   = '0;
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    note_d     = rom_data[3:0];
                    dur_d      = rom_data[DUR_W+3:4];
                    tick_d     = '0;
                    tone_cnt_d = '0;
                    tone_d     = 1'b0;
                    state_d    = ST_PLAY;
                end
                ST_PLAY: begin
                    if (pause) begin
                        tone_d  = 1'b0;
                        state_d = ST_PAUSED;
                    end else begin
                        // Square wave: toggle every HP clocks, silent for a rest.
                        if (note_code != 4'd0) begin
                            if (tone_wrap) begin
                                tone_cnt_d = '0;
                                tone_d     = ~tone;
                            end else begin
                                tone_cnt_d = tone_cnt + hp_t'(1);
                            end
                        end
                        if (tick_wrap) begin
                            tick_d = '0;
                            if (dur_cnt == '0) begin
                                if (pos < LAST_ADDR) begin
                                    pos_d   = pos + ADDR_W'(1);
                                    state_d = ST_FETCH;
                                end else if (loop_en) begin
                                    pos_d   = '0;
                                    state_d = ST_FETCH;
                                end else begin
                                    tone_d  = 1'b0;
                                    done_d  = 1'b1;
                                    state_d = ST_IDLE;
                                end
                            end else begin
                                dur_d = dur_cnt - DUR_W'(1);
                            end
                        end else begin
                            tick_d = tick_cnt + TICK_W'(1);
                        end
                    end
                end
                ST_PAUSED: begin
                    tone_d = 1'b0;
                    if (!pause) begin
                        state_d = ST_PLAY;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/music_sequencer.md
# music_sequencer

Parametrised single-voice music sequencer. It walks a note ROM at a programmable tick rate and decodes each ROM word into a note code and a duration. It produces a square-wave tone at the note pitch, with play, pause, stop and loop control. It sits between the board clock domain and the speaker/LED pins, and replaces the fixed 4 Hz divider, 138-step counter, note decoder and speaker divider chain with one controllable block.

## Interface
- CLK_HZ, 1_000_000: input clock frequency in Hz.
- TICK_HZ, 4: duration-unit rate; TICK = CLK_HZ/TICK_HZ clocks per tick (must be ≥ 2).
- ADDR_W, 8: ROM address width.
- SONG_LEN, 139: number of ROM words played; last address is SONG_LEN-1 (≤ 2^ADDR_W).
- DUR_W, 4: duration field width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- play  in  1  pulse; starts playback from address 0 when idle
- pause  in  1  level; freezes playback while high
- stop  in  1  pulse; aborts to idle from any state
- loop_en  in  1  level; restart at address 0 after the last note
- rom_addr  out  ADDR_W  ROM address
- rom_data  in  DUR_W+4  synchronous ROM data, one-cycle latency; [3:0] = note code, [DUR_W+3:4] = duration d
- tone  out  1  square-wave speaker drive
- note_code  out  4  current note, for the LEDs
- high  out  1  1 when note_code ≥ 8 (high octave)
- busy  out  1  1 in any state except IDLE
- done  out  1  one-cycle pulse at the end of a non-looped song

## Operation
- Note codes:
  - 0 = rest.
  - 1–7 = C4 D4 E4 F4 G4 A4 B4 (262 294 330 349 392 440 494 Hz).
  - 8–14 = C5–B5 (523 587 659 698 784 880 988 Hz).
  - 15 = C6 (1047 Hz).
- Half-period table: HP[n] = max(1, CLK_HZ/(2·f_n)) in integer clocks, evaluated at elaboration.
- Note length: a note lasts (d+1)·TICK clocks of PLAY time. d = 0 gives one tick.
- States: IDLE, FETCH, WAIT, PLAY, PAUSED.
  - IDLE: on play, pos←0 and go to FETCH. Otherwise stay.
  - FETCH: go to WAIT. The ROM samples rom_addr = pos on this edge.
  - WAIT: latch rom_data, then:
    - note_code←[3:0], dur_cnt←d, tick_cnt←0, tone_cnt←0, tone←0;
    - go to PLAY.
  - PLAY:
    - tick_cnt counts 0..TICK-1.
    - On wrap with dur_cnt = 0, the note ends:
      - if pos < SONG_LEN-1: pos←pos+1, go to FETCH;
      - else if loop_en: pos←0, go to FETCH;
      - else: go to IDLE and pulse done.
    - On wrap with dur_cnt ≠ 0: dur_cnt decrements.
    - If pause = 1, go to PAUSED. This takes precedence over the note end in the same cycle; counters hold.
  - PAUSED: all counters hold and tone is forced to 0. Return to PLAY when pause = 0.
- Tone generation:
  - In PLAY with note_code ≠ 0, tone_cnt counts 0..HP-1; on wrap, tone toggles.
  - For a rest, tone stays 0.
  - In FETCH and WAIT, tone and tone_cnt hold.
- Command priority: stop > pause > play.
  - stop from any state: go to IDLE, pos←0, tone←0, note_code←0; done is not pulsed.
  - play is ignored unless the state is IDLE.
  - pause is ignored outside PLAY and PAUSED.
- rom_addr = pos at all times.
- high is derived combinationally from note_code.

## Timing
- Reset values: all outputs are 0 (tone, note_code, high, rom_addr, busy, done); state = IDLE; all counters are 0.
- play sampled high at edge k:
  - FETCH from k;
  - WAIT from k+1;
  - note_code is valid and PLAY starts from edge k+2.
- Inter-note gap: 2 clocks (FETCH + WAIT), not counted in the note length.
- Period between successive note_code updates: (d+1)·TICK + 2 clocks.
- First tone toggle: HP clocks after entering PLAY. Period is 2·HP.
- done: high for exactly 1 cycle, on the same edge that busy falls.
- Reset asserted mid-note: outputs clear immediately (asynchronous). After release, the block stays IDLE until play.

## Test plan
Bench parameters: CLK_HZ = 1_000_000, TICK_HZ = 1000 (TICK = 1000), SONG_LEN = 3.

1. ROM = {d=1,n=8}, {d=0,n=0}, {d=0,n=15}; play pulse, loop_en = 0.
   - note_code = 8 two clocks after play; tone first rises 956 clocks later.
   - note_code = 0 after 2002 clocks, with tone = 0 throughout.
   - note_code = 15 follows with HP = 477; high = 1.
   - done pulses at the end; busy falls on the same edge.
2. Same ROM with loop_en = 1: after note 2, rom_addr returns to 0 and note_code = 8 again; done never pulses.
3. Pause for 5000 clocks, 500 clocks into note 0: tone = 0 and counters frozen. After release, the note finishes 1500 PLAY clocks later (total 2000 PLAY clocks).
4. stop mid-note, with pause and play asserted in the same cycle: next cycle IDLE; busy = 0, tone = 0, note_code = 0, rom_addr = 0, no done. A play pulse while busy (no stop) is ignored and rom_addr is unchanged.
5. Reset asserted 300 clocks into note 0: all outputs 0 asynchronously. After release, the block stays IDLE for 100 clocks with no play.
6. CLK_HZ = 1000 override: HP saturates to 1 for every note, and tone toggles every clock while a note is active.
